// File: rtl/uart_word_tx.sv
// uart_word_tx: parametrised UART transmitter that serialises a NUM_BYTES word
// onto one TX line. Bytes go out little-endian and bits go out LSB first. Each
// byte is framed with a start bit, an optional parity bit and 1 or 2 stop bits.
// Words are accepted through a valid/ready handshake.
// Optional feature: define UART_WORD_TX_HEX_EN to send each word as uppercase
// ASCII hex, most significant nibble first, followed by CR LF.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int NUM_BYTES    = 4,
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1
) (
    input  logic                   Clk,
    input  logic                   rst,
    input  logic [NUM_BYTES*8-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_uart_tx,
    output logic                   o_busy,
    output logic                   o_byte_done
);
    localparam int W = NUM_BYTES * 8;
`ifdef UART_WORD_TX_HEX_EN
    localparam int NUM_CHARS = 2 * NUM_BYTES + 2;
`else
    localparam int NUM_CHARS = NUM_BYTES;
`endif
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(NUM_CHARS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

`ifdef UART_WORD_TX_HEX_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character idx of the hex rendering: nibbles MS first, then CR, LF.
    function automatic logic [7:0] char_at(input logic [W-1:0] w, input logic [IDX_W-1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < 2 * NUM_BYTES; k++)
            if (idx == IDX_W'(k)) c = hex_ascii(w[W-4-4*k +: 4]);
        if (idx == IDX_W'(2 * NUM_BYTES))     c = 8'h0D;
        if (idx == IDX_W'(2 * NUM_BYTES + 1)) c = 8'h0A;
        return c;
    endfunction
`else
    // Raw byte idx of the word, byte 0 in the low bits.
    function automatic logic [7:0] char_at(input logic [W-1:0] w, input logic [IDX_W-1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++)
            if (idx == IDX_W'(k)) c = w[8*k +: 8];
        return c;
    endfunction
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;    // data bit index, reused as stop-bit index
    logic [IDX_W-1:0] byte_idx_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [W-1:0]     word_q;
    logic             tx_q, ready_q, busy_q, done_q;

    logic [7:0]       char_d;
    logic             par_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next character to load: byte 0 of the incoming word on accept, else the
    // following character of the held word. Parity is precomputed with it.
    always_comb begin
        char_d = (state_q == S_IDLE) ? char_at(i_data, '0)
                                     : char_at(word_q, byte_idx_q + 1'b1);
        par_d  = (PARITY == 1) ? ~(^char_d) : (^char_d);
    end

    // Frame FSM; every output is a register updated alongside the state.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            word_q     <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (i_valid && ready_q) begin
                        word_q     <= i_data;
                        byte_idx_q <= '0;
                        shift_q    <= char_d;
                        par_q      <= par_d;
                        cnt_q      <= '0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            if (PARITY != 0) begin
                                tx_q    <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                            done_q     <= 1'b1;
                            bit_idx_q  <= '0;
                            byte_idx_q <= byte_idx_q + 1'b1;
                            if (byte_idx_q == IDX_W'(NUM_CHARS - 1)) begin
                                tx_q    <= 1'b1;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                // back-to-back start bit, no idle gap inside a word
                                shift_q <= char_d;
                                par_q   <= par_d;
                                tx_q    <= 1'b0;
                                state_q <= S_START;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_uart_tx   = tx_q;
    assign o_ready     = ready_q;
    assign o_busy      = busy_q;
    assign o_byte_done = done_q;

endmodule
